im_byte_writer: RTL and testbench
=================================

Name: im_byte_writer

Overview:
- Write-side companion to the byte-addressed instruction memory.
- Accepts 32-bit instruction words over a valid/ready stream and writes each one to the memory byte array over a 1-byte-per-cycle write port.
- Byte order is big-endian, matching the IM read port: word[31:24] goes to addr, word[7:0] goes to addr+3.
- Used by the testbench/boot path to load a program before the CPU leaves reset.

Parameters:
- MEM_SIZE, 128, instruction memory size in bytes; must equal INSTR_MEM_SIZE.
- CNT_W, 6, width of word_count; covers MEM_SIZE/4 words plus one.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  32  byte start address; sampled with start.
- word_count  input  CNT_W  number of words to load; sampled with start.
- in_valid  input  1  in_data holds a word.
- in_data  input  32  instruction word.
- in_ready  output  1  writer can accept a word this cycle.
- mem_we  output  1  byte write strobe.
- mem_addr  output  32  byte address for the write.
- mem_wdata  output  8  byte to write.
- busy  output  1  high from the cycle after an accepted start until returning to IDLE.
- done  output  1  1-cycle pulse when a load completes successfully.
- err  output  1  sticky error; cleared by the next accepted start or by reset.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=IDLE
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - busy=0, done=0, err=0
  - internal counters and word buffer = 0
- FSM states: IDLE, CHECK, WAIT_WORD, WRITE, DONE.
- IDLE:
  - start=1 latches base_addr and word_count, clears err, goes to CHECK.
- CHECK (1 cycle):
  - If base_addr[1:0]!=0, or base_addr + 4*word_count > MEM_SIZE (computed at 33 bits, no wrap): set err=1, go to IDLE. No memory write occurs.
  - Else if word_count==0: go to DONE.
  - Else: go to WAIT_WORD.
- WAIT_WORD:
  - in_ready=1 (registered, asserted for the whole state).
  - A handshake (in_valid & in_ready) latches in_data, sets byte index=0, goes to WRITE.
- WRITE (exactly 4 cycles per word, in_ready=0):
  - mem_we=1.
  - mem_addr = cur_addr + idx.
  - mem_wdata = byte idx of the word, with idx0=[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0].
  - After idx3: cur_addr += 4 and remaining -= 1. If remaining reaches 0, go to DONE; else go to WAIT_WORD.
- DONE:
  - done=1 for one cycle, then IDLE.
- Timing:
  - busy = (state != IDLE).
  - Latency: a word accepted in cycle N has its bytes written in cycles N+1..N+4. The next in_ready is in cycle N+5.
  - Throughput: one word per 5 cycles.
- Boundary and simultaneous events:
  - start while busy is ignored.
  - in_valid outside WAIT_WORD is ignored; no data is consumed.
  - Last legal word exactly at MEM_SIZE-4 is allowed. One word past that boundary is rejected in CHECK.
  - mem_addr never exceeds MEM_SIZE-1 during mem_we.
  - Reset mid-WRITE: mem_we drops immediately (async). The partially written word remains in memory. No done pulse.

Optional Feature:
- Macro: IM_BYTE_WRITER_CHECKSUM_EN.
- Defined:
  - Adds output checksum [31:0].
  - checksum is cleared on an accepted start and on reset.
  - Each accepted word adds in_data modulo 2^32.
  - The value is stable from the done pulse until the next start.
- Undefined:
  - No checksum port and no accumulator logic.
  - All other behaviour is identical.

Decomposition:
- Shared package im_pkg holds:
  - INSTR_MEM_SIZE (128)
  - state enum: IDLE/CHECK/WAIT_WORD/WRITE/DONE
  - BYTE_W=8, WORD_BYTES=4
- No sub-module. The word-to-byte selection is an inline mux; the design is one FSM plus counters.

Test Plan:
- Basic load:
  - Stimulus: start, base=0, count=2, words 0x20080005 then 0x01095020, in_valid always high.
  - Response: bytes 20,08,00,05,01,09,50,20 at addr 0..7 in consecutive WRITE cycles; done pulses once; err=0.
  - Readback: IM reads 0x20080005 at addr 0.
- Backpressure:
  - Stimulus: in_valid low for 3 cycles in WAIT_WORD.
  - Response: in_ready stays 1; no mem_we; no state advance until valid.
- Bounds:
  - base=124, count=1 → accepted; last byte written at 127.
  - base=124, count=2 → err=1 after CHECK; zero mem_we.
  - base=2 → err=1.
- Zero count and ignored start:
  - count=0 → done 2 cycles after start; no writes.
  - start pulsed during WRITE → ignored; sequence unchanged.
- Reset mid-write:
  - Stimulus: rst_n low during idx 2 of word 0.
  - Response: mem_we=0 immediately; busy=0, done=0; a new start then loads normally.
- Checksum (macro defined):
  - Stimulus: words 0xFFFFFFFF, 0x00000002.
  - Response: checksum=0x00000001 at done.

Source files
------------

// File: rtl/im_pkg.sv
// Shared definitions for the instruction-memory write path.
// Holds the memory size, byte/word geometry and the writer FSM state encoding.
package im_pkg;

    localparam int INSTR_MEM_SIZE = 128;
    localparam int BYTE_W         = 8;
    localparam int WORD_BYTES     = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHECK     = 3'd1,
        WAIT_WORD = 3'd2,
        WRITE     = 3'd3,
        DONE      = 3'd4
    } imState_t;

endpackage

// File: rtl/im_byte_writer.sv
// im_byte_writer: takes 32-bit instruction words from a valid/ready stream and
// writes them big-endian, one byte per cycle, into the instruction memory.
// Optional feature macro: IM_BYTE_WRITER_CHECKSUM_EN adds a 32-bit running sum
// of accepted words on output port checksum.
module im_byte_writer
    import im_pkg::*;
#(
    parameter int MEM_SIZE = INSTR_MEM_SIZE,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [31:0]      in_data,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [7:0]       mem_wdata,
    output logic             busy,
    output logic             done,
    output logic             err
`ifdef IM_BYTE_WRITER_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    imState_t              stateReg;
    imState_t              stateNext;
    logic [31:0]           curAddrReg;
    logic [CNT_W-1:0]      remainingReg;
    logic [31:0]           wordBufReg;
    logic [1:0]            byteIdxReg;
    logic                  errReg;
    logic [32:0]           endAddr;
    logic                  checkFail;
    logic                  handshake;
    logic                  lastByte;
    logic [BYTE_W-1:0]     byteLane [WORD_BYTES];

    // Big-endian lane split: lane 0 is the most significant byte.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        assign byteLane[gi] = wordBufReg[(WORD_BYTES-1-gi)*BYTE_W +: BYTE_W];
    end

    // End address is formed at 33 bits so a huge base cannot wrap into range.
    assign endAddr   = {1'b0, curAddrReg} + {{(33-CNT_W-2){1'b0}}, remainingReg, 2'b00};
    assign checkFail = (curAddrReg[1:0] != 2'b00) || (endAddr > 33'(MEM_SIZE));
    assign handshake = (stateReg == WAIT_WORD) && in_valid;
    assign lastByte  = (byteIdxReg == 2'(WORD_BYTES-1));

    // Outputs decode straight from registered state, so reset clears them at once.
    assign in_ready  = (stateReg == WAIT_WORD);
    assign mem_we    = (stateReg == WRITE);
    assign mem_addr  = (stateReg == WRITE) ? (curAddrReg + {30'd0, byteIdxReg}) : 32'd0;
    assign mem_wdata = (stateReg == WRITE) ? byteLane[byteIdxReg] : 8'd0;
    assign busy      = (stateReg != IDLE);
    assign done      = (stateReg == DONE);
    assign err       = errReg;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic for the load sequence.
    always_comb begin
        stateNext = stateReg;
        unique case (stateReg)
            IDLE: begin
                if (start) stateNext = CHECK;
            end
            CHECK: begin
                if (checkFail)                 stateNext = IDLE;
                else if (remainingReg == '0)   stateNext = DONE;
                else                           stateNext = WAIT_WORD;
            end
            WAIT_WORD: begin
                if (in_valid) stateNext = WRITE;
            end
            WRITE: begin
                if (lastByte) begin
                    stateNext = (remainingReg == CNT_W'(1)) ? DONE : WAIT_WORD;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Address, word-count, data buffer and sticky error bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curAddrReg   <= 32'd0;
            remainingReg <= '0;
            wordBufReg   <= 32'd0;
            byteIdxReg   <= 2'd0;
            errReg       <= 1'b0;
        end else begin
            unique case (stateReg)
                IDLE: begin
                    if (start) begin
                        curAddrReg   <= base_addr;
                        remainingReg <= word_count;
                        errReg       <= 1'b0;
                    end
                end
                CHECK: begin
                    if (checkFail) errReg <= 1'b1;
                end
                WAIT_WORD: begin
                    if (handshake) begin
                        wordBufReg <= in_data;
                        byteIdxReg <= 2'd0;
                    end
                end
                WRITE: begin
                    byteIdxReg <= byteIdxReg + 2'd1;
                    if (lastByte) begin
                        curAddrReg   <= curAddrReg + 32'(WORD_BYTES);
                        remainingReg <= remainingReg - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef IM_BYTE_WRITER_CHECKSUM_EN
    logic [31:0] checksumReg;

    // Running modulo-2^32 sum of accepted words, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksumReg <= 32'd0;
        end else if ((stateReg == IDLE) && start) begin
            checksumReg <= 32'd0;
        end else if (handshake) begin
            checksumReg <= checksumReg + in_data;
        end
    end

    assign checksum = checksumReg;
`endif

endmodule

// File: tb/tb_im_byte_writer.sv
// Directed testbench for im_byte_writer with a byte-array memory model.
// Define IM_BYTE_WRITER_CHECKSUM_EN for both bench and RTL to cover the checksum.
module tb_im_byte_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [5:0]  word_count = 6'd0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = 32'd0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
`ifdef IM_BYTE_WRITER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    int weCount = 0;
    int oobCount = 0;
    logic [7:0] memModel [0:127];

    im_byte_writer #(.MEM_SIZE(128), .CNT_W(6)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef IM_BYTE_WRITER_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous byte memory driven by the writer port.
    always @(posedge clk) begin
        if (mem_we) begin
            weCount <= weCount + 1;
            if (mem_addr > 32'd127) oobCount <= oobCount + 1;
            memModel[mem_addr[6:0]] <= mem_wdata;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic startLoad(input logic [31:0] b, input logic [5:0] c);
        start = 1'b1;
        base_addr = b;
        word_count = c;
        tick();
        start = 1'b0;
        chk("check_busy", 32'(busy), 32'd1);
        chk("check_ready", 32'(in_ready), 32'd0);
    endtask

    // Present a word in WAIT_WORD and verify its four byte writes; optionally
    // pulse start mid-write to show it is ignored.
    task automatic sendWord(input logic [31:0] addr, input logic [31:0] w, input bit pokeStart);
        logic [7:0] expByte;
        chk("wait_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = w;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expByte = w[31 - 8*i -: 8];
            chk("we", 32'(mem_we), 32'd1);
            chk("addr", mem_addr, addr + 32'(i));
            chk("wdata", 32'(mem_wdata), 32'(expByte));
            chk("ready_in_write", 32'(in_ready), 32'd0);
            $display("write addr=%0d data=0x%02h", mem_addr, mem_wdata);
            start = pokeStart && (i == 1);
            base_addr = pokeStart ? 32'd64 : base_addr;
            tick();
            start = 1'b0;
        end
    endtask

    initial begin
        int weBefore;
        for (int i = 0; i < 128; i++) memModel[i] = 8'h00;

        // Reset values
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic two-word load with a start pulse during the second word's writes
        startLoad(32'd0, 6'd2);
        tick();
        sendWord(32'd0, 32'h20080005, 1'b0);
        sendWord(32'd4, 32'h01095020, 1'b1);
        chk("basic_done", 32'(done), 32'd1);
        chk("basic_err", 32'(err), 32'd0);
        tick();
        chk("basic_done_pulse", 32'(done), 32'd0);
        chk("basic_idle", 32'(busy), 32'd0);
        chk("basic_readback0", {memModel[0], memModel[1], memModel[2], memModel[3]}, 32'h20080005);
        chk("basic_readback1", {memModel[4], memModel[5], memModel[6], memModel[7]}, 32'h01095020);
        chk("basic_we_count", 32'(weCount), 32'd8);
        $display("basic load done, writes=%0d", weCount);

        // Backpressure: valid held low in WAIT_WORD
        startLoad(32'd124, 6'd1);
        tick();
        weBefore = weCount;
        for (int i = 0; i < 3; i++) begin
            chk("bp_ready", 32'(in_ready), 32'd1);
            chk("bp_we", 32'(mem_we), 32'd0);
            tick();
        end
        chk("bp_no_write", 32'(weCount), 32'(weBefore));
        // Last legal word ends at byte 127
        sendWord(32'd124, 32'hA1B2C3D4, 1'b0);
        chk("top_done", 32'(done), 32'd1);
        chk("top_err", 32'(err), 32'd0);
        chk("top_byte127", 32'(memModel[127]), 32'hD4);
        tick();
        $display("boundary word at 124 done");

        // One word past the end is rejected
        weBefore = weCount;
        startLoad(32'd124, 6'd2);
        tick();
        chk("oob_err", 32'(err), 32'd1);
        chk("oob_idle", 32'(busy), 32'd0);
        chk("oob_no_done", 32'(done), 32'd0);
        tick();
        chk("oob_no_write", 32'(weCount), 32'(weBefore));
        $display("out-of-range load rejected, err=%0b", err);

        // Misaligned base; err must first clear on the accepted start
        startLoad(32'd2, 6'd1);
        chk("misalign_err_cleared", 32'(err), 32'd0);
        tick();
        chk("misalign_err", 32'(err), 32'd1);
        chk("misalign_idle", 32'(busy), 32'd0);
        tick();
        $display("misaligned load rejected, err=%0b", err);

        // Zero count: done two cycles after start, no writes
        weBefore = weCount;
        startLoad(32'd40, 6'd0);
        chk("zero_not_done_yet", 32'(done), 32'd0);
        tick();
        chk("zero_done", 32'(done), 32'd1);
        chk("zero_err", 32'(err), 32'd0);
        tick();
        chk("zero_idle", 32'(busy), 32'd0);
        chk("zero_no_write", 32'(weCount), 32'(weBefore));
        $display("zero-count load done");

        // Reset during byte index 2 of the first word
        startLoad(32'd8, 6'd1);
        tick();
        in_valid = 1'b1;
        in_data = 32'hAABBCCDD;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("mid_we_before", 32'(mem_we), 32'd1);
        chk("mid_addr_idx2", mem_addr, 32'd10);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_we_drop", 32'(mem_we), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_done", 32'(done), 32'd0);
        chk("mid_partial", {memModel[8], memModel[9], memModel[10], memModel[11]}, 32'hAABB0000);
        #2;
        rst_n = 1'b1;
        tick();
        $display("reset mid-write handled");
        startLoad(32'd8, 6'd1);
        tick();
        sendWord(32'd8, 32'h11223344, 1'b0);
        chk("reload_done", 32'(done), 32'd1);
        chk("reload_word", {memModel[8], memModel[9], memModel[10], memModel[11]}, 32'h11223344);
        tick();

`ifdef IM_BYTE_WRITER_CHECKSUM_EN
        // Checksum wraps modulo 2^32
        startLoad(32'd16, 6'd2);
        chk("cks_cleared", checksum, 32'd0);
        tick();
        sendWord(32'd16, 32'hFFFFFFFF, 1'b0);
        sendWord(32'd20, 32'h00000002, 1'b0);
        chk("cks_done", 32'(done), 32'd1);
        chk("cks_value", checksum, 32'h00000001);
        tick();
        chk("cks_stable", checksum, 32'h00000001);
        $display("checksum=0x%08h", checksum);
`endif

        chk("never_out_of_range", 32'(oobCount), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
